// File: rtl/guess_game_ctrl.sv
// N-player code-guessing game controller: secret entry, turn sequencing,
// right/wrong scoring, win/draw hold timer and final secret reveal.
module guess_game_ctrl #(
  parameter  int NUM_PLAYERS = 2,
  parameter  int DIGITS      = 4,
  parameter  int DIGIT_W     = 4,
  parameter  int MAX_TURNS   = 8,
  parameter  int WIN_HOLD    = 50_000_000,
  localparam int CODE_W      = DIGITS * DIGIT_W,
  localparam int PW          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CW          = $clog2(DIGITS + 1),
  localparam int TW          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              submit,
  input  logic [CODE_W-1:0] code_in,
  input  logic [PW-1:0]     reveal_sel,
  output logic [2:0]        state,
  output logic [PW-1:0]     player,
  output logic [TW-1:0]     round,
  output logic              score_valid,
  output logic [CW-1:0]     last_right,
  output logic [CW-1:0]     last_wrong,
  output logic [PW-1:0]     winner,
  output logic              winner_valid,
  output logic [CODE_W-1:0] secret_out
);

  typedef enum logic [2:0] {
    SETUP  = 3'd0,
    GUESS  = 3'd1,
    SCORE  = 3'd2,
    WIN    = 3'd3,
    DRAW   = 3'd4,
    REVEAL = 3'd5
  } state_t;

  localparam int TMW = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
  localparam logic [PW-1:0]  LAST_P    = PW'(NUM_PLAYERS - 1);
  localparam logic [PW-1:0]  ONE_P     = PW'(1);
  localparam logic [TW-1:0]  LAST_R    = TW'(MAX_TURNS);
  localparam logic [TW-1:0]  ONE_R     = TW'(1);
  localparam logic [TMW-1:0] HOLD_LAST = TMW'(WIN_HOLD - 1);
  localparam logic [TMW-1:0] ONE_T     = TMW'(1);
  localparam logic [CW-1:0]  ONE_C     = CW'(1);

  state_t            cur, nxt;
  logic [CODE_W-1:0] secret   [NUM_PLAYERS];
  logic [CODE_W-1:0] secret_n [NUM_PLAYERS];
  logic [CODE_W-1:0] guess, guess_n;
  logic [TMW-1:0]    timer, timer_n;
  logic [PW-1:0]     player_n, winner_n, target_idx;
  logic [TW-1:0]     round_n;
  logic              score_valid_n, winner_valid_n;
  logic [CW-1:0]     last_right_n, last_wrong_n;
  logic [CODE_W-1:0] target;

  logic [CW-1:0]      hits, common, rank, avail;
  logic [DIGIT_W-1:0] gd;

  assign target_idx = (player == LAST_P) ? '0 : player + ONE_P;
  assign target     = secret[target_idx];
  assign state      = cur;
  assign secret_out = (cur == REVEAL && reveal_sel <= LAST_P) ? secret[reveal_sel] : '0;

  // Common-digit count without a per-value histogram: the k-th occurrence of a
  // value in the guess counts iff the target holds at least k of that value,
  // which sums to min(count_guess, count_target) per value.
  always_comb begin
    hits   = '0;
    common = '0;
    rank   = '0;
    avail  = '0;
    gd     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      gd    = code_in[i*DIGIT_W +: DIGIT_W];
      rank  = '0;
      avail = '0;
      if (gd == target[i*DIGIT_W +: DIGIT_W]) hits = hits + ONE_C;
      for (int unsigned j = 0; j < DIGITS; j++) begin
        if (j <= i && code_in[j*DIGIT_W +: DIGIT_W] == gd) rank = rank + ONE_C;
        if (target[j*DIGIT_W +: DIGIT_W] == gd) avail = avail + ONE_C;
      end
      if (rank <= avail) common = common + ONE_C;
    end
  end

  always_comb begin
    nxt            = cur;
    player_n       = player;
    round_n        = round;
    score_valid_n  = 1'b0;
    last_right_n   = last_right;
    last_wrong_n   = last_wrong;
    winner_n       = winner;
    winner_valid_n = winner_valid;
    guess_n        = guess;
    timer_n        = timer;
    secret_n       = secret;
    case (cur)
      SETUP: begin
        if (submit) begin
          secret_n[player] = code_in;
          if (player == LAST_P) begin
            player_n = '0;
            round_n  = ONE_R;
            nxt      = GUESS;
          end else begin
            player_n = player + ONE_P;
          end
        end
      end
      GUESS: begin
        if (submit) begin
          guess_n       = code_in;
          last_right_n  = hits;
          last_wrong_n  = common - hits;
          score_valid_n = 1'b1;
          nxt           = SCORE;
        end
      end
      SCORE: begin
        // A full positional match is exactly guess == target.
        if (guess == target) begin
          winner_n       = player;
          winner_valid_n = 1'b1;
          nxt            = WIN;
        end else if (player == LAST_P && round == LAST_R) begin
          nxt = DRAW;
        end else if (player == LAST_P) begin
          player_n = '0;
          round_n  = round + ONE_R;
          nxt      = GUESS;
        end else begin
          player_n = player + ONE_P;
          nxt      = GUESS;
        end
      end
      WIN, DRAW: begin
        if (timer == HOLD_LAST) begin
          timer_n = '0;
          nxt     = REVEAL;
        end else begin
          timer_n = timer + ONE_T;
        end
      end
      REVEAL: ;
      default: nxt = SETUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur          <= SETUP;
      player       <= '0;
      round        <= '0;
      score_valid  <= 1'b0;
      last_right   <= '0;
      last_wrong   <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      guess        <= '0;
      timer        <= '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) secret[p] <= '0;
    end else begin
      cur          <= nxt;
      player       <= player_n;
      round        <= round_n;
      score_valid  <= score_valid_n;
      last_right   <= last_right_n;
      last_wrong   <= last_wrong_n;
      winner       <= winner_n;
      winner_valid <= winner_valid_n;
      guess        <= guess_n;
      timer        <= timer_n;
      secret       <= secret_n;
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl: directed and random games against a
// histogram-based scoring model and a turn-sequence model.
module tb_guess_game_ctrl;
  localparam int NP = 3, DG = 4, DW = 4, MT = 2, WH = 8;

  logic        clk = 1'b0, rst = 1'b1, submit = 1'b0;
  logic [15:0] code_in = '0;
  logic [1:0]  reveal_sel = '0;
  logic [2:0]  state;
  logic [1:0]  player;
  logic [7:0]  round;
  logic        score_valid;
  logic [2:0]  last_right, last_wrong;
  logic [1:0]  winner;
  logic        winner_valid;
  logic [15:0] secret_out;

  guess_game_ctrl #(.NUM_PLAYERS(NP), .DIGITS(DG), .DIGIT_W(DW), .MAX_TURNS(MT), .WIN_HOLD(WH)) dut (
    .clk(clk), .rst(rst), .submit(submit), .code_in(code_in), .reveal_sel(reveal_sel),
    .state(state), .player(player), .round(round), .score_valid(score_valid),
    .last_right(last_right), .last_wrong(last_wrong), .winner(winner),
    .winner_valid(winner_valid), .secret_out(secret_out));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, pulses = 0, pushes = 0;
  int exp_q[$];
  logic [15:0] sec [NP];
  int m_player, m_round, m_winner, m_wv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns right*16 + wrong using per-value digit histograms.
  function automatic int ref_score(input logic [15:0] g, input logic [15:0] t);
    int r, common;
    int cg[16], ct[16];
    logic [3:0] a, b;
    r = 0; common = 0;
    for (int v = 0; v < 16; v++) begin cg[v] = 0; ct[v] = 0; end
    for (int i = 0; i < DG; i++) begin
      a = g[i*4 +: 4]; b = t[i*4 +: 4];
      if (a == b) r++;
      cg[a]++; ct[b]++;
    end
    for (int v = 0; v < 16; v++) common += (cg[v] < ct[v]) ? cg[v] : ct[v];
    return r * 16 + (common - r);
  endfunction

  always @(negedge clk) begin
    if (score_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_score: got score_valid=1 expected no pulse at %0t", $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("score_right", 32'(last_right), 32'(e / 16));
        chk("score_wrong", 32'(last_wrong), 32'(e % 16));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [15:0] c);
    code_in = c; submit = 1'b1; step(); submit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; submit = 1'b0; code_in = '0;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_player", 32'(player), 0);
    chk("rst_round", 32'(round), 0);
    chk("rst_valid", 32'(score_valid), 0);
    chk("rst_wv", 32'(winner_valid), 0);
    rst = 1'b0;
    for (int p = 0; p < NP; p++) sec[p] = '0;
    m_player = 0; m_round = 0; m_winner = 0; m_wv = 0;
  endtask

  task automatic setup(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
    logic [15:0] s [NP];
    s[0] = s0; s[1] = s1; s[2] = s2;
    for (int p = 0; p < NP; p++) begin
      press(s[p]); sec[p] = s[p];
      if (p < NP - 1) begin
        chk("setup_state", 32'(state), 0);
        chk("setup_player", 32'(player), 32'(p + 1));
        chk("setup_secret_hidden", 32'(secret_out), 0);
      end
    end
    m_player = 0; m_round = 1;
    chk("setup_done_state", 32'(state), 1);
    chk("setup_done_player", 32'(player), 0);
    chk("setup_done_round", 32'(round), 1);
  endtask

  // outcome: 0 next guess, 1 win, 2 draw
  task automatic guess(input logic [15:0] g, input bit dbl, output int outcome);
    int e;
    e = ref_score(g, sec[(m_player + 1) % NP]);
    exp_q.push_back(e); pushes++;
    code_in = g; submit = 1'b1; step();
    if (!dbl) submit = 1'b0;
    chk("score_state", 32'(state), 2);
    step(); submit = 1'b0;
    if (e / 16 == DG) begin
      m_winner = m_player; m_wv = 1; outcome = 1;
    end else if (m_player == NP - 1 && m_round == MT) begin
      outcome = 2;
    end else begin
      outcome = 0;
      if (m_player == NP - 1) begin m_player = 0; m_round++; end
      else m_player++;
    end
    chk("post_state", 32'(state), (outcome == 1) ? 3 : (outcome == 2) ? 4 : 1);
    chk("post_player", 32'(player), 32'(m_player));
    chk("post_round", 32'(round), 32'(m_round));
    chk("post_wv", 32'(winner_valid), 32'(m_wv));
    if (m_wv != 0) chk("post_winner", 32'(winner), 32'(m_winner));
    chk("valid_one_cycle", 32'(score_valid), 0);
    chk("right_held", 32'(last_right), 32'(e / 16));
  endtask

  task automatic dwell_reveal(input int st);
    int n;
    n = 0;
    while (state == 3'(st) && n < 40) begin n++; step(); end
    chk("dwell_cycles", 32'(n), WH);
    chk("reveal_state", 32'(state), 5);
    chk("reveal_player", 32'(player), 32'(m_player));
    chk("reveal_round", 32'(round), 32'(m_round));
    chk("reveal_wv", 32'(winner_valid), 32'(m_wv));
    for (int p = 0; p < NP; p++) begin
      reveal_sel = 2'(p); #1;
      chk("reveal_secret", 32'(secret_out), 32'(sec[p]));
    end
    press(16'($urandom));
    chk("reveal_terminal", 32'(state), 5);
  endtask

  logic [15:0] rnd_wrong;
  task automatic pick_wrong();
    logic [15:0] t;
    t = sec[(m_player + 1) % NP];
    rnd_wrong = 16'($urandom);
    if (rnd_wrong == t) rnd_wrong = rnd_wrong ^ 16'h0001;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int oc;
    logic [15:0] gsel;
    // Game 1: basic scoring and a win by the last player.
    do_reset();
    setup(16'h1234, 16'h5678, 16'h9ABC);
    guess(16'h4321, 1'b0, oc);
    guess(16'h9ACB, 1'b0, oc);
    guess(16'h1234, 1'b0, oc);
    chk("win_outcome", 32'(oc), 1);
    dwell_reveal(3);

    // Game 2: duplicate digits, back-to-back submit, draw.
    do_reset();
    setup(16'hAAAA, 16'h1123, 16'h5555);
    guess(16'h1111, 1'b0, oc);
    pick_wrong(); guess(rnd_wrong, 1'b1, oc);
    pick_wrong(); guess(rnd_wrong, 1'b0, oc);
    guess(16'h2311, 1'b0, oc);
    pick_wrong(); guess(rnd_wrong, 1'b0, oc);
    pick_wrong(); guess(rnd_wrong, 1'b0, oc);
    chk("draw_outcome", 32'(oc), 2);
    dwell_reveal(4);

    // Random games.
    for (int gm = 0; gm < 6; gm++) begin
      do_reset();
      setup(16'($urandom), 16'($urandom), 16'($urandom));
      oc = 0;
      for (int k = 0; k < NP * MT && oc == 0; k++) begin
        if ($urandom_range(0, 4) == 0) gsel = sec[(m_player + 1) % NP];
        else begin
          gsel = sec[(m_player + 1) % NP];
          gsel[$urandom_range(0, 3) * 4 +: 4] = 4'($urandom);
          if ($urandom_range(0, 1) == 1) gsel = 16'($urandom);
        end
        guess(gsel, 1'($urandom_range(0, 1)), oc);
      end
      dwell_reveal(oc == 1 ? 3 : 4);
    end

    // Reset during SCORE.
    do_reset();
    setup(16'h1357, 16'h2468, 16'hFEDC);
    code_in = 16'h2468; submit = 1'b1; step(); submit = 1'b0;
    chk("pre_rst_state", 32'(state), 2);
    rst = 1'b1; #1;
    chk("midrst_state", 32'(state), 0);
    chk("midrst_valid", 32'(score_valid), 0);
    chk("midrst_right", 32'(last_right), 0);
    chk("midrst_wrong", 32'(last_wrong), 0);
    chk("midrst_player", 32'(player), 0);
    chk("midrst_round", 32'(round), 0);
    chk("midrst_wv", 32'(winner_valid), 0);
    step(); rst = 1'b0; step();
    press(16'h7777);
    chk("after_rst_state", 32'(state), 0);
    chk("after_rst_player", 32'(player), 1);

    step(); step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("pulse_count", 32'(pulses), 32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
